mcpu_plus_core: RTL and testbench
=================================

MCPU_PLUS_CORE -- requirements
Module: mcpu_plus_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, accumulator and register width; legal 8..16.
REQ-002 SHALL have parameter PC_W, default 8, program-counter width; legal 4..DATA_W.
REQ-003 SHALL have parameter NREGS, default 8, implemented registers; legal 1..8.
REQ-004 SHALL have parameter STACK_DEPTH, default 4, return-stack entries; legal 1..16.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port inst_in  input  6  instruction executed at each rising edge.
REQ-008 SHALL have port cpu_out  output  DATA_W  pc zero-extended while clk=1, accu while clk=0 (combinational mux).
REQ-009 SHALL have port stk_err  output  1  sticky flag: return-stack overflow or underflow.

Function
REQ-010 SHALL execute exactly one instruction per rising edge while rst_n=1; no stalls or multi-cycle ops.
REQ-011 State: accu[DATA_W-1:0], carry, iflag, pc[PC_W-1:0], regs[0..NREGS-1], stack, sp (0..STACK_DEPTH), stk_err.
REQ-012 imm = inst_in[3:0]; off8 = iflag ? {imm, accu[3:0]} : sign-extend(imm); off = off8 sign-extended or truncated to PC_W.
REQ-013 00iiii BCC: carry=0 -> pc += off; carry=1 -> pc += 1; carry cleared in both cases.
REQ-014 01iiii LDI: iflag=0 -> accu = sign-extend(imm); iflag=1 -> accu = {accu[DATA_W-5:0], imm} (prefix chaining); carry unchanged.
REQ-015 iflag SHALL be 1 in the cycle after an LDI and 0 after any other instruction.
REQ-016 100rrr ADD: {carry, accu} = accu + regs[r], DATA_W+1-bit sum.
REQ-017 101rrr STA: regs[r] = accu at the rising edge (synchronous; no phase-dependent write).
REQ-018 110rrr LDA: accu = regs[r]; carry unchanged.
REQ-019 r >= NREGS: reads return 0, writes ignored.
REQ-020 111000 NOT: accu = ~accu, carry unchanged; 111001 NEG: accu = -accu (two's complement), carry = (old accu == 0).
REQ-021 111010 CALL: push pc+1, pc = accu[PC_W-1:0].
REQ-022 111100 RET: pop into pc.
REQ-023 111011, 111101, 111110, 111111: NOP, pc += 1.
REQ-024 Every non-branch instruction SHALL advance pc by 1, except CALL/RET/taken BCC.
REQ-025 pc arithmetic SHALL wrap modulo 2^PC_W; accu arithmetic modulo 2^DATA_W.
REQ-026 CALL with sp=STACK_DEPTH: oldest entry discarded (circular), sp stays STACK_DEPTH, stk_err set.
REQ-027 RET with sp=0: pc += 1, sp stays 0, stk_err set.
REQ-028 stk_err SHALL remain 1 until reset.

Reset
REQ-029 rst_n=0 at a rising edge SHALL clear accu, carry, iflag, pc, sp, stk_err, mid-instruction or mid-prefix-chain alike; inst_in ignored that cycle.
REQ-030 regs and stack contents SHALL NOT be reset; STA during reset SHALL NOT write.
REQ-031 cpu_out after reset SHALL read 0 in both clk phases.

Configuration
REQ-032 Macro MCPU_RETSTACK_EN defined: REQ-021, -022, -026, -027 apply.
REQ-033 Macro undefined: no stack or sp; 111010 is JMPA (pc = accu[PC_W-1:0]), 111100 is NOP; stk_err tied 0.

Verification
REQ-034 Reset, then LDI 0x5, ADD r9 invalid via LDA r7 with NREGS=4 -> accu=0x00, cpu_out(clk=0)=0x00.
REQ-035 LDI 0x7, LDI 0xF, STA r2, ADD r2 -> accu 0x7F, then 0xFE, carry=0; repeat ADD path with accu=0xFF+0x01 -> accu=0x00, carry=1.
REQ-036 pc=0x10, carry=0, BCC 0xE -> pc=0x0E; LDI 0x3, BCC 0x1 -> pc += 0x13; with carry=1 -> pc += 1, carry=0.
REQ-037 NEG with accu=0x00 -> accu=0x00, carry=1; NEG with 0x01 -> 0xFF, carry=0; NOT 0xA5 -> 0x5A.
REQ-038 MCPU_RETSTACK_EN, STACK_DEPTH=4: 5 CALLs then 5 RETs -> stk_err=1 after 5th CALL; 4 RETs return newest-first; 5th RET pc += 1.
REQ-039 rst_n=0 asserted after first LDI of a chain -> next LDI 0x2 yields accu=0x02 (no chaining), pc counts from 0.

Source files
------------

// File: rtl/mcpu_plus_core.sv
// mcpu_plus_core: single-cycle accumulator CPU with prefix-chained immediates and register file.
// Define MCPU_RETSTACK_EN for CALL/RET with a circular return stack; otherwise 111010 is JMPA.
module mcpu_plus_core #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 8,
    parameter int NREGS       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        inst_in,
    output logic [DATA_W-1:0] cpu_out,
    output logic              stk_err
);
    localparam logic [5:0] OP_NOT  = 6'b111000;
    localparam logic [5:0] OP_NEG  = 6'b111001;
    localparam logic [5:0] OP_CALL = 6'b111010;
    localparam logic [5:0] OP_RET  = 6'b111100;

    logic [DATA_W-1:0] accu, accu_nx, rd, pc_ext;
    logic [DATA_W-1:0] regs [8];
    logic [DATA_W:0]   sum;
    logic [PC_W-1:0]   pc, pc_nx, pc_inc, off, ret_pc;
    logic [7:0]        off8;
    logic [3:0]        imm;
    logic [2:0]        r;
    logic              carry, carry_nx, iflag, reg_ok, ret_empty;

    assign imm    = inst_in[3:0];
    assign r      = inst_in[2:0];
    assign reg_ok = int'(r) < NREGS;
    assign rd     = reg_ok ? regs[r] : '0;
    assign sum    = {1'b0, accu} + {1'b0, rd};
    assign pc_inc = pc + PC_W'(1);
    // After an LDI the low accu nibble extends the branch offset to 8 bits
    assign off8   = iflag ? {imm, accu[3:0]} : 8'($signed(imm));
    assign off    = PC_W'($signed(off8));

    always_comb begin
        pc_ext = '0;
        pc_ext[PC_W-1:0] = pc;
    end

    assign cpu_out = clk ? pc_ext : accu;

    always_comb begin
        accu_nx  = accu;
        carry_nx = carry;
        pc_nx    = pc_inc;
        casez (inst_in)
            6'b00????: begin
                pc_nx    = carry ? pc_inc : pc + off;
                carry_nx = 1'b0;
            end
            6'b01????: accu_nx = iflag ? {accu[DATA_W-5:0], imm} : DATA_W'($signed(imm));
            6'b100???: {carry_nx, accu_nx} = sum;
            6'b110???: accu_nx = rd;
            OP_NOT:    accu_nx = ~accu;
            OP_NEG: begin
                accu_nx  = -accu;
                carry_nx = accu == '0;
            end
            OP_CALL:   pc_nx = accu[PC_W-1:0];
            OP_RET:    pc_nx = ret_empty ? pc_inc : ret_pc;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accu  <= '0;
            carry <= 1'b0;
            iflag <= 1'b0;
            pc    <= '0;
        end else begin
            accu  <= accu_nx;
            carry <= carry_nx;
            iflag <= inst_in[5:4] == 2'b01;
            pc    <= pc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && inst_in[5:3] == 3'b101 && reg_ok) regs[r] <= accu;
    end

`ifdef MCPU_RETSTACK_EN
    localparam int TW  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [TW-1:0]   top, top_inc, top_dec;
    logic [SPW-1:0]  sp;
    logic            push, pop, full;

    assign push      = inst_in == OP_CALL;
    assign pop       = inst_in == OP_RET;
    assign full      = sp == SPW'(STACK_DEPTH);
    assign ret_empty = sp == '0;
    // top is the next write slot; a full push overwrites the oldest entry
    assign top_inc   = top == TW'(STACK_DEPTH - 1) ? '0 : top + TW'(1);
    assign top_dec   = top == '0 ? TW'(STACK_DEPTH - 1) : top - TW'(1);
    assign ret_pc    = stack[top_dec];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top     <= '0;
            sp      <= '0;
            stk_err <= 1'b0;
        end else begin
            if (push) begin
                top <= top_inc;
                sp  <= full ? sp : sp + SPW'(1);
            end
            if (pop && !ret_empty) begin
                top <= top_dec;
                sp  <= sp - SPW'(1);
            end
            stk_err <= stk_err | (push && full) | (pop && ret_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) stack[top] <= pc_inc;
    end
`else
    assign ret_empty = 1'b1;
    assign ret_pc    = pc_inc;
    assign stk_err   = STACK_DEPTH < 1;
`endif
endmodule

// File: tb/tb_mcpu_plus_core.sv
// tb_mcpu_plus_core: directed program with a behavioural model checked every half cycle.
module tb_mcpu_plus_core;
    localparam int NR    = 4;
    localparam int DEPTH = 4;
    localparam logic [5:0] BCC = 6'o00, LDI = 6'o20, ADD = 6'o40, STA = 6'o50, LDA = 6'o60;
    localparam logic [5:0] NOT = 6'o70, NEG = 6'o71, CALL = 6'o72, NOP = 6'o73, RET = 6'o74;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] inst_in = '0;
    logic [7:0] cpu_out, last_pc;
    logic       stk_err;
    int errors = 0, checks = 0;
    int m_accu = 0, m_carry = 0, m_iflag = 0, m_pc = 0, m_err = 0;
    int m_regs [8];
    int stk [$];

    mcpu_plus_core #(.DATA_W(8), .PC_W(8), .NREGS(NR), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .cpu_out(cpu_out), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model(input logic [5:0] i, input logic r);
        int imm, simm, off, npc, rv, rr;
        if (!r) begin
            m_accu = 0; m_carry = 0; m_iflag = 0; m_pc = 0; m_err = 0;
            stk.delete();
            return;
        end
        imm  = int'(i[3:0]);
        simm = imm > 7 ? imm - 16 : imm;
        rr   = int'(i[2:0]);
        rv   = rr < NR ? m_regs[rr] : 0;
        npc  = m_pc + 1;
        if (i[5:4] == 2'b00) begin
            off = m_iflag ? imm * 16 + m_accu % 16 : simm;
            if (off > 127) off -= 256;
            if (m_carry == 0) npc = m_pc + off;
            m_carry = 0;
        end else if (i[5:4] == 2'b01) m_accu = m_iflag ? m_accu * 16 + imm : simm;
        else if (i[5:3] == 3'b100) begin
            m_accu += rv;
            m_carry = int'(m_accu > 255);
        end else if (i[5:3] == 3'b101) begin
            if (rr < NR) m_regs[rr] = m_accu;
        end else if (i[5:3] == 3'b110) m_accu = rv;
        else if (i == NOT) m_accu = 255 - m_accu;
        else if (i == NEG) begin
            m_carry = int'(m_accu == 0);
            m_accu = 256 - m_accu;
        end else if (i == CALL) begin
`ifdef MCPU_RETSTACK_EN
            if (stk.size() == DEPTH) begin
                stk.delete(0);
                m_err = 1;
            end
            stk.push_back(npc & 255);
`endif
            npc = m_accu;
        end
`ifdef MCPU_RETSTACK_EN
        else if (i == RET) begin
            if (stk.size() == 0) m_err = 1;
            else npc = stk.pop_back();
        end
`endif
        m_accu &= 255;
        m_pc = npc & 255;
        m_iflag = int'(i[5:4] == 2'b01);
    endtask

    task automatic step(input logic [5:0] i, input logic r = 1'b1);
        inst_in = i;
        rst_n = r;
        @(posedge clk);
        model(i, r);
        #1 last_pc = cpu_out;
        @(negedge clk);
        #2;
    endtask

    initial forever begin
        @(posedge clk);
        #1 chk("pc", cpu_out, 8'(m_pc));
        @(negedge clk);
        #1 chk("accu", cpu_out, 8'(m_accu));
        chk("stk_err", stk_err, 8'(m_err));
    end

    initial begin
        step(NOP, 1'b0);
        step(NOP, 1'b0);
        chk("rst_accu", cpu_out, 8'h00);
        chk("rst_pc", last_pc, 8'h00);
        chk("rst_err", stk_err, 8'h00);
        step(LDI | 6'd5);
        step(LDA | 6'd7);
        chk("lda_invalid", cpu_out, 8'h00);
        step(LDI | 6'd0);
        for (int k = 0; k < 4; k++) step(STA | 6'(k));
        step(LDI | 6'd7);
        step(LDI | 6'hF);
        chk("chain_7f", cpu_out, 8'h7F);
        step(STA | 6'd2);
        step(ADD | 6'd2);
        chk("add_fe", cpu_out, 8'hFE);
        step(LDI | 6'hF);
        chk("ldi_sext", cpu_out, 8'hFF);
        step(STA | 6'd1);
        step(LDI | 6'd1);
        step(ADD | 6'd1);
        chk("add_wrap", cpu_out, 8'h00);
        step(BCC | 6'd5);
        chk("bcc_carry", last_pc, 8'h10);
        step(BCC | 6'hE);
        chk("bcc_back", last_pc, 8'h0E);
        step(LDI | 6'd3);
        step(BCC | 6'd1);
        chk("bcc_prefix", last_pc, 8'h22);
        step(LDI | 6'hF);
        step(STA | 6'd3);
        step(LDI | 6'd1);
        step(ADD | 6'd3);
        step(BCC | 6'd7);
        chk("bcc_carry2", last_pc, 8'h27);
        step(BCC | 6'd0);
        chk("bcc_self", last_pc, 8'h27);
        step(NEG);
        chk("neg0", cpu_out, 8'h00);
        step(BCC | 6'd4);
        chk("neg0_carry", last_pc, 8'h29);
        step(LDI | 6'd1);
        step(NEG);
        chk("neg1", cpu_out, 8'hFF);
        step(BCC | 6'd2);
        chk("neg1_nocarry", last_pc, 8'h2D);
        step(LDI | 6'hA);
        step(LDI | 6'd5);
        step(NOT);
        chk("not", cpu_out, 8'h5A);
        step(LDI | 6'hF);
        step(CALL);
        chk("jump_ff", last_pc, 8'hFF);
        step(NOP);
        chk("pc_wrap", last_pc, 8'h00);
        step(NOP, 1'b0);
`ifdef MCPU_RETSTACK_EN
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) chk("err_before_5th", stk_err, 8'h00);
            step(LDI | 6'(k));
            step(CALL);
        end
        chk("err_after_5th", stk_err, 8'h01);
        begin
            logic [7:0] exp_ret [5] = '{8'h06, 8'h05, 8'h04, 8'h03, 8'h04};
            for (int k = 0; k < 5; k++) begin
                step(RET);
                chk("ret_pc", last_pc, exp_ret[k]);
            end
        end
        chk("err_sticky", stk_err, 8'h01);
`else
        step(LDI | 6'd3);
        step(CALL);
        chk("jmpa", last_pc, 8'h03);
        step(RET);
        chk("ret_nop", last_pc, 8'h04);
        chk("err_tied", stk_err, 8'h00);
`endif
        step(LDI | 6'd7);
        step(STA | 6'd0, 1'b0);
        step(LDI | 6'd2);
        chk("no_chain", cpu_out, 8'h02);
        chk("pc_restart", last_pc, 8'h01);
        chk("err_cleared", stk_err, 8'h00);
        step(LDA | 6'd0);
        chk("sta_in_reset", cpu_out, 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
